// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the stream controller and its compression core.
// Holds the initial hash values (SHA-256 and SHA-224), the controller state enum,
// the block/word sizing constants and the final-word padding helper.
package sha256_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_W     = 512;
  localparam int unsigned DIGEST_W    = 256;
  localparam int unsigned BLOCK_WORDS = BLOCK_W / WORD_W;

  localparam logic [DIGEST_W-1:0] IV_SHA256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [DIGEST_W-1:0] IV_SHA224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  typedef enum logic [1:0] {ST_FILL, ST_HASH, ST_PAD, ST_DONE} state_e;

  // Keep the first nbytes bytes of a big-endian word and append the 0x80 marker.
  // nbytes of 4 or more returns the word untouched (marker goes into the next word).
  function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] data,
                                                 input logic [2:0]        nbytes);
    case (nbytes)
      3'd0:    return 32'h8000_0000;
      3'd1:    return {data[31:24], 24'h80_0000};
      3'd2:    return {data[31:16], 16'h8000};
      3'd3:    return {data[31:8], 8'h80};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/sha256_core.sv
// SHA-256 compression core: one round per clock, 64 rounds per block.
// Ports:
//   i_clk, i_rst  clock and active-high asynchronous reset
//   i_start       load i_data / i_vin and begin a compression
//   i_data        512-bit message block, word 0 in [511:480]
//   i_vin         incoming chaining value H0..H7, H0 in [255:224]
//   o_vout        chaining value after this block (held until the next block ends)
//   o_done        one-cycle pulse when o_vout is updated
module sha256_core
  import sha256_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [BLOCK_W-1:0]  i_data,
  input  logic [DIGEST_W-1:0] i_vin,
  output logic [DIGEST_W-1:0] o_vout,
  output logic                o_done
);

  localparam logic [2047:0] K_ALL = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0]         w_q [16];  // sliding schedule window, w_q[0] = W[t]
  logic [31:0]         v_q [8];   // working variables a..h
  logic [31:0]         v_nx [8];
  logic [DIGEST_W-1:0] vin_q, vout_q, vout_nx;
  logic [5:0]          round_q;
  logic                busy_q, done_q;
  logic [31:0]         k_word, t1, t2, w_nx;

  always_comb begin
    // K[63 - r] sits at bit offset 32*(63 - r); for 6 bits 63 - r == ~r.
    k_word = K_ALL[{~round_q, 5'b0} +: 32];
    t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
       + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + k_word + w_q[0];
    t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
       + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    v_nx[0] = t1 + t2;
    v_nx[1] = v_q[0];
    v_nx[2] = v_q[1];
    v_nx[3] = v_q[2];
    v_nx[4] = v_q[3] + t1;
    v_nx[5] = v_q[4];
    v_nx[6] = v_q[5];
    v_nx[7] = v_q[6];
    // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
    w_nx = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
         + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    vout_nx = '0;
    for (int i = 0; i < 8; i++) begin
      vout_nx[255-32*i -: 32] = vin_q[255-32*i -: 32] + v_nx[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      for (int i = 0; i < 8; i++) v_q[i] <= '0;
      vin_q   <= '0;
      vout_q  <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_start) begin
        for (int i = 0; i < 16; i++) w_q[i] <= i_data[511-32*i -: 32];
        for (int i = 0; i < 8; i++) v_q[i] <= i_vin[255-32*i -: 32];
        vin_q   <= i_vin;
        round_q <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        for (int i = 0; i < 8; i++) v_q[i] <= v_nx[i];
        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
        w_q[15] <= w_nx;
        round_q <= round_q + 6'd1;
        if (round_q == 6'd63) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          vout_q <= vout_nx;
        end
      end
    end
  end

  assign o_vout = vout_q;
  assign o_done = done_q;

endmodule

// File: rtl/sha256_stream_ctrl.sv
// Streaming SHA-256 front end: accepts 32-bit big-endian message words, fills
// 512-bit blocks, applies final padding plus the 64-bit bit length, chains the
// blocks through sha256_core and issues the digest.
// Ports:
//   i_clk, i_rst_n   clock and active-low asynchronous reset
//   i_valid/o_ready  word handshake; i_data/i_last/i_nbytes qualify the word
//   i_sha224         (only with SHA256_SHA224_EN) selects SHA-224, sampled on the first word
//   o_digest         last issued digest, H0 in [255:224]
//   o_digest_valid   one-cycle pulse when o_digest updates
//   o_busy           a message is in progress
// Build option: define SHA256_SHA224_EN to add SHA-224 support.
module sha256_stream_ctrl
  import sha256_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [WORD_W-1:0]   i_data,
  input  logic                i_last,
  input  logic [2:0]          i_nbytes,
`ifdef SHA256_SHA224_EN
  input  logic                i_sha224,
`endif
  output logic [DIGEST_W-1:0] o_digest,
  output logic                o_digest_valid,
  output logic                o_busy
);

  state_e              state_q, state_d, after_q, after_d;
  logic [WORD_W-1:0]   blk_q [BLOCK_WORDS];
  logic [WORD_W-1:0]   blk_d [BLOCK_WORDS];
  logic [3:0]          idx_q, idx_d;
  logic [4:0]          zfrom_q, zfrom_d;  // first word to zero in the pad step (16 = none)
  logic                need80_q, need80_d;  // 0x80 marker still owed at word zfrom_q
  logic [63:0]         len_q, len_d;
  logic [DIGEST_W-1:0] chain_q, chain_d, digest_q, digest_d;
  logic                first_q, first_d, started_q, started_d, busy_q, busy_d, dvalid_d;
  logic                dvalid_q;
  logic                is224;
  logic                core_rst, core_start, core_done;
  logic [BLOCK_W-1:0]  core_block;
  logic [DIGEST_W-1:0] core_vin, core_vout;

`ifdef SHA256_SHA224_EN
  logic sha224_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sha224_q <= 1'b0;
    end else if (state_q == ST_FILL && i_valid && !busy_q) begin
      sha224_q <= i_sha224;
    end
  end
  assign is224 = sha224_q;
`else
  assign is224 = 1'b0;
`endif

  assign core_rst = ~i_rst_n;
  assign core_vin = first_q ? (is224 ? IV_SHA224 : IV_SHA256) : chain_q;

  always_comb begin
    core_block = '0;
    for (int i = 0; i < 16; i++) core_block[511-32*i -: 32] = blk_q[i];
  end

  always_comb begin
    state_d    = state_q;
    after_d    = after_q;
    blk_d      = blk_q;
    idx_d      = idx_q;
    zfrom_d    = zfrom_q;
    need80_d   = need80_q;
    len_d      = len_q;
    chain_d    = chain_q;
    digest_d   = digest_q;
    first_d    = first_q;
    started_d  = started_q;
    busy_d     = busy_q;
    dvalid_d   = 1'b0;
    o_ready    = 1'b0;
    core_start = 1'b0;
    case (state_q)
      ST_FILL: begin
        o_ready = 1'b1;
        if (i_valid) begin
          busy_d = 1'b1;
          idx_d  = idx_q + 4'd1;
          if (i_last) begin
            if (i_nbytes[2]) begin
              blk_d[idx_q] = i_data;
              len_d        = len_q + 64'd32;
              need80_d     = 1'b1;
            end else begin
              blk_d[idx_q] = pad_word(i_data, i_nbytes);
              len_d        = len_q + 64'({i_nbytes[1:0], 3'b000});
              need80_d     = 1'b0;
            end
            zfrom_d = {1'b0, idx_q} + 5'd1;
            state_d = ST_PAD;
          end else begin
            blk_d[idx_q] = i_data;
            len_d        = len_q + 64'd32;
            if (idx_q == 4'd15) begin
              after_d = ST_FILL;
              state_d = ST_HASH;
            end
          end
        end
      end
      ST_PAD: begin
        for (int i = 0; i < 16; i++) begin
          if (5'(i) >= zfrom_q) blk_d[i] = '0;
          if (need80_q && 5'(i) == zfrom_q) blk_d[i] = 32'h8000_0000;
        end
        // Length fits only if the marker word sits at index 13 or below.
        if ({1'b0, zfrom_q} + {5'b0, need80_q} <= 6'd14) begin
          blk_d[14] = len_q[63:32];
          blk_d[15] = len_q[31:0];
          after_d   = ST_DONE;
        end else begin
          after_d  = ST_PAD;
          zfrom_d  = 5'd0;
          need80_d = need80_q && (zfrom_q == 5'd16);
        end
        idx_d   = '0;
        state_d = ST_HASH;
      end
      ST_HASH: begin
        if (!started_q) begin
          core_start = 1'b1;
          started_d  = 1'b1;
        end else if (core_done) begin
          started_d = 1'b0;
          chain_d   = core_vout;
          first_d   = 1'b0;
          state_d   = after_q;
        end
      end
      ST_DONE: begin
        digest_d = is224 ? {chain_q[255:32], 32'h0} : chain_q;
        dvalid_d = 1'b1;
        len_d    = '0;
        idx_d    = '0;
        first_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_FILL;
      after_q   <= ST_FILL;
      for (int i = 0; i < 16; i++) blk_q[i] <= '0;
      idx_q     <= '0;
      zfrom_q   <= '0;
      need80_q  <= 1'b0;
      len_q     <= '0;
      chain_q   <= '0;
      digest_q  <= '0;
      first_q   <= 1'b1;
      started_q <= 1'b0;
      busy_q    <= 1'b0;
      dvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      after_q   <= after_d;
      blk_q     <= blk_d;
      idx_q     <= idx_d;
      zfrom_q   <= zfrom_d;
      need80_q  <= need80_d;
      len_q     <= len_d;
      chain_q   <= chain_d;
      digest_q  <= digest_d;
      first_q   <= first_d;
      started_q <= started_d;
      busy_q    <= busy_d;
      dvalid_q  <= dvalid_d;
    end
  end

  assign o_digest       = digest_q;
  assign o_digest_valid = dvalid_q;
  assign o_busy         = busy_q;

  sha256_core u_core (
    .i_clk   (i_clk),
    .i_rst   (core_rst),
    .i_start (core_start),
    .i_data  (core_block),
    .i_vin   (core_vin),
    .o_vout  (core_vout),
    .o_done  (core_done)
  );

endmodule

// File: doc/sha256_stream_ctrl.md
SHA256_STREAM_CTRL -- requirements
Module: sha256_stream_ctrl

Interface
REQ-001 Parameters: none; all sizing is fixed by SHA-256.
REQ-002 i_clk  input  1  sole clock; all state on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  input word valid.
REQ-005 o_ready  output  1  controller accepts a word this cycle.
REQ-006 i_data  input  32  message word, big-endian, first byte in [31:24].
REQ-007 i_last  input  1  word is the final word of the message.
REQ-008 i_nbytes  input  3  valid bytes in the last word (0..4); ignored when i_last=0.
REQ-009 o_digest  output  256  final hash H0..H7, H0 in [255:224].
REQ-010 o_digest_valid  output  1  one-cycle pulse when o_digest is updated.
REQ-011 o_busy  output  1  a message is in progress (first word accepted, digest not yet issued).

Function
REQ-012 Transfers SHALL occur only on cycles with i_valid && o_ready; i_data is ignored on all other cycles.
REQ-013 FSM states SHALL be ST_FILL, ST_HASH, ST_PAD and ST_DONE:
- ST_FILL: o_ready=1; store words into a 16-word buffer at index 0..15.
- Word 15 stored without i_last -> ST_HASH.
- i_last -> ST_PAD.
REQ-014 ST_HASH SHALL pulse the core's i_start for exactly one cycle, then hold o_ready=0 until the core's o_done; it then returns to ST_FILL (more data), ST_PAD (pad block pending) or ST_DONE (final block).
REQ-015 Padding SHALL place byte 0x80 immediately after the last valid byte, zero the remaining bytes of that word, and zero the following words.
- i_nbytes=4: 0x80000000 goes into the next word.
- i_nbytes=0: 0x80000000 replaces the last word.
REQ-016 Words 14..15 of the final block SHALL hold the 64-bit message length in bits, big-endian; the counter wraps modulo 2^64.
REQ-017 If the 0x80 byte lands in word 14 or 15, the current block SHALL be zero-filled and hashed, then a second block of zeros plus length is hashed.
REQ-018 The first block SHALL use the SHA-256 IV as i_vin; every later block uses the previous o_vout.
REQ-019 ST_DONE SHALL register o_digest, pulse o_digest_valid for one cycle, clear the length and index counters, and return to ST_FILL.
REQ-020 o_digest SHALL hold its value until the next message's digest is issued.
REQ-021 An empty message (first word has i_last=1, i_nbytes=0) SHALL hash a single pad-only block.
REQ-022 Back-to-back messages: o_ready SHALL be low for the ST_DONE cycle only; the next message may start on the following cycle.

Reset
REQ-023 On i_rst_n low, asynchronously: FSM=ST_FILL, all counters=0, buffer=0, o_digest=0, o_digest_valid=0, o_busy=0.
REQ-024 After reset, o_ready SHALL be 1 on the first clock edge with i_rst_n high.
REQ-025 The core SHALL be reset from ~i_rst_n.
REQ-026 Reset mid-hash SHALL discard the partial message; no digest pulse follows.

Configuration
REQ-027 Macro SHA256_SHA224_EN:
- Defined: adds input i_sha224 (1 bit), sampled with the first word. When set, the IV is the SHA-224 IV and o_digest carries H0..H6 in [255:32] with [31:0]=0.
- Undefined: the port is absent and only SHA-256 is supported.

Structure
REQ-028 Package sha256_pkg SHALL hold the IV constants (SHA-256 and SHA-224), the FSM state enum, and the block/word width constants.
REQ-029 sub-module: one instance of sha256_core (i_clk, i_rst, i_start, i_data[511:0], i_vin, o_vout, o_done), the existing compression core.

Verification
REQ-030 Input "abc" = one word 0x61626300 with i_last=1, i_nbytes=3 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-031 Empty message -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-032 Digits "1234567890" x8 (80 bytes, 2 blocks) -> f371bc4a 311f2b00 9eef952d d83ca80e 2b60026c 8e935592 d0f9c308 453c813e.
REQ-033 "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (56 bytes, forces an extra pad block) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-034 Assert i_rst_n=0 during ST_HASH, then send "abc" -> no stale digest pulse appears, and the correct "abc" digest is produced.
REQ-035 With SHA256_SHA224_EN defined, i_sha224=1 and input "abc" -> digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, with [31:0]=0.
